inst_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory read port: owns the PC, drives the fetch address and captures the returned word.
- Buffers {pc, inst} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts redirects (jump/branch) from execute.
- Sits between the combinational instruction memory and the decode stage in the npc core.

---
 rtl/inst_fetch_unit.sv | 97 +++++++++
 tb/tb_inst_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the combinational instruction memory and
// buffers {pc, inst} pairs for decode. Optional ebreak halt via IFU_EBREAK_HALT_EN.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        halted
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  logic [31:0]      pc_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [31:0]      pc_mem   [FIFO_DEPTH];
  logic [31:0]      inst_mem [FIFO_DEPTH];
  logic             fetch_fire;
  logic             pop;
  logic             not_empty;
  logic             halt_stop;

`ifdef IFU_EBREAK_HALT_EN
  logic halted_reg;

  // Halt takes effect at the edge that captures the ebreak; the ebreak itself is still buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_reg <= 1'b0;
    end else if (redirect_valid) begin
      halted_reg <= 1'b0;
    end else if (fetch_fire && (imem_inst == EBREAK_INST)) begin
      halted_reg <= 1'b1;
    end
  end

  assign halt_stop = halted_reg;
  assign halted    = halted_reg;
`else
  assign halt_stop = 1'b0;
  assign halted    = 1'b0;
`endif

  assign not_empty  = (count_reg != '0);
  // Fullness uses the registered count, so a full buffer never pushes even while popping.
  assign fetch_fire = !redirect_valid && (count_reg < DEPTH_C) && !halt_stop;
  assign pop        = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg     <= RESET_PC;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (redirect_valid) begin
      pc_reg     <= redirect_pc;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fetch_fire) begin
        pc_reg     <= pc_reg + 32'd4;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(fetch_fire) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (fetch_fire) begin
      pc_mem[wr_ptr_reg]   <= pc_reg;
      inst_mem[wr_ptr_reg] <= imem_inst;
    end
  end

  assign imem_pc   = pc_reg;
  assign out_valid = not_empty && !redirect_valid;
  assign out_pc    = not_empty ? pc_mem[rd_ptr_reg]   : 32'd0;
  assign out_inst  = not_empty ? inst_mem[rd_ptr_reg] : 32'd0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit against a queue-based reference model,
// plus directed sequences for latency, backpressure, redirect, wrap and reset.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk;
  logic        rst;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        halted;

  logic [31:0] mem [64];

  int checks;
  int failures;

  // Reference model: next fetch PC, buffered {pc, inst} pairs, halt flag.
  logic [31:0] m_pc;
  logic [63:0] m_q [$];
  logic        m_halted;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .imem_pc(imem_pc),
    .imem_inst(imem_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst(out_inst),
    .out_pc(out_pc),
    .halted(halted)
  );

  assign imem_inst = mem[imem_pc[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_q.delete();
    m_halted = 1'b0;
  endtask

  // Called at a falling edge: drive inputs, check outputs, advance one clock, update model.
  task automatic step(input logic redir, input logic [31:0] tgt, input logic rdy);
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] fetched;
    redirect_valid = redir;
    redirect_pc    = tgt;
    out_ready      = rdy;
    #1;
    exp_valid = (m_q.size() != 0) && !redir;
    exp_pc    = (m_q.size() != 0) ? m_q[0][63:32] : 32'd0;
    exp_inst  = (m_q.size() != 0) ? m_q[0][31:0]  : 32'd0;
    check_val("imem_pc", imem_pc, m_pc);
    check_val("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    if (!redir) begin
      check_val("out_pc", out_pc, exp_pc);
      check_val("out_inst", out_inst, exp_inst);
    end
    check_val("halted", {31'd0, halted}, {31'd0, m_halted});
    @(posedge clk);
    if (redir) begin
      m_q.delete();
      m_pc     = tgt;
      m_halted = 1'b0;
    end else begin
      logic can_push;
      can_push = (m_q.size() < DEPTH) && !m_halted;
      if (exp_valid && rdy) begin
        $display("xfer pc=%h inst=%h", exp_pc, exp_inst);
        void'(m_q.pop_front());
      end
      if (can_push) begin
        fetched = mem[m_pc[7:2]];
        m_q.push_back({m_pc, fetched});
`ifdef IFU_EBREAK_HALT_EN
        if (fetched == EBREAK) m_halted = 1'b1;
`endif
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b0;
    for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + k;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_imem_pc", imem_pc, RESET_PC);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_out_pc", out_pc, 32'd0);
    check_val("rst_out_inst", out_inst, 32'd0);
    rst = 1'b0;

    // Streaming with decode always ready.
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1);
    // Backpressure, then drain.
    step(1'b1, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1);
    // Redirect while the buffer holds stale entries.
    step(1'b1, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    step(1'b1, 32'h40, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);
    // Redirect while full with decode ready.
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0);
    step(1'b1, 32'h80, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1);
    // PC wrap past the top of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);

    // Asynchronous reset mid-stream with two entries buffered.
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0);
    rst = 1'b1;
    #1;
    check_val("async_rst_imem_pc", imem_pc, RESET_PC);
    check_val("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("async_rst_out_pc", out_pc, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);

`ifdef IFU_EBREAK_HALT_EN
    mem[3] = EBREAK;
    step(1'b1, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b1);
    check_val("halt_imem_pc", imem_pc, 32'd16);
    step(1'b1, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1);
    mem[3] = 32'h1000_0003;
`endif

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic [31:0] t;
      logic        rd;
      r  = ($urandom_range(0, 15) == 0);
      t  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      rd = ($urandom_range(0, 3) != 0);
      step(r, t, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
